// File: rtl/config_register_bank.sv
// -----------------------------------------------------------------------------
// config_register_bank
//
// Purpose:
//   Controller for the configuration write bus. Each incoming (address, data)
//   word is one of two things:
//     - a write into a local bank of NUM_REGS registers, or
//     - a read-back command.
//   A read-back command serialises the selected register onto a TX stream,
//   LSB packet first.
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   in_data    incoming register data
//   in_addr    incoming register address
//   in_rdy     incoming word valid; the producer holds it until acked
//   in_ack     incoming word accepted this cycle (combinational)
//   regs_flat  register k at bits [(k+1)*REG_DATA_WIDTH-1 : k*REG_DATA_WIDTH]
//   wr_strobe  one-cycle pulse; bit k means register k was just written
//   err_addr   one-cycle pulse: unmapped address or bad read-back index
//   tx_data    read-back packet
//   tx_rdy     read-back packet valid
//   tx_ack     read-back packet consumed
// -----------------------------------------------------------------------------
module config_register_bank #(
    parameter int                          REG_ADDR_WIDTH = 16,
    parameter int                          REG_DATA_WIDTH = 16,
    parameter int                          TX_DATA_WIDTH  = 8,
    parameter int                          NUM_REGS       = 8,
    parameter logic [REG_ADDR_WIDTH-1:0]   BASE_ADDR      = '0,
    parameter logic [REG_ADDR_WIDTH-1:0]   READBACK_ADDR  = '1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [REG_DATA_WIDTH-1:0]          in_data,
    input  logic [REG_ADDR_WIDTH-1:0]          in_addr,
    input  logic                               in_rdy,
    output logic                               in_ack,
    output logic [NUM_REGS*REG_DATA_WIDTH-1:0] regs_flat,
    output logic [NUM_REGS-1:0]                wr_strobe,
    output logic                               err_addr,
    output logic [TX_DATA_WIDTH-1:0]           tx_data,
    output logic                               tx_rdy,
    input  logic                               tx_ack
);

    localparam int PACKETS = REG_DATA_WIDTH / TX_DATA_WIDTH;
    localparam int IDX_W   = $clog2(NUM_REGS);
    localparam int CNT_W   = (PACKETS > 1) ? $clog2(PACKETS) : 1;

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } state_t;

    state_t                    state_reg;
    state_t                    state_next;
    logic [REG_DATA_WIDTH-1:0] regs_reg [NUM_REGS];
    logic [REG_DATA_WIDTH-1:0] shadow_reg;
    logic [CNT_W-1:0]          count_reg;
    logic                      tx_rdy_reg;
    logic [NUM_REGS-1:0]       wr_strobe_reg;
    logic                      err_addr_reg;

    // ---------------------------------------------------------------------
    // Address decode
    // ---------------------------------------------------------------------
    logic [REG_ADDR_WIDTH-1:0] addr_offset;
    logic                      is_readback;
    logic                      is_mapped;
    logic                      idx_ok;
    logic                      last_pkt;
    logic                      xfer;

    // The offset is taken at address width. The explicit lower-bound test
    // stops addresses below BASE_ADDR from wrapping into the bank.
    assign addr_offset = in_addr - BASE_ADDR;
    assign is_readback = (in_addr == READBACK_ADDR);
    assign is_mapped   = !is_readback && (in_addr >= BASE_ADDR) &&
                         (addr_offset < REG_ADDR_WIDTH'(NUM_REGS));
    assign idx_ok      = (in_data < REG_DATA_WIDTH'(NUM_REGS));
    assign last_pkt    = (count_reg == CNT_W'(PACKETS - 1));

    // in_ack already includes in_rdy, so in_ack alone marks a transfer.
    assign xfer        = in_ack;

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (xfer && is_readback && idx_ok) begin
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                if (tx_ack && last_pkt) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM: output logic
    // ---------------------------------------------------------------------
    // Input is stalled for the whole of a read-back, so the shadow copy can
    // never be overtaken by a later write.
    always_comb begin
        in_ack = 1'b0;
        if (!rst && (state_reg == ST_IDLE)) begin
            in_ack = in_rdy;
        end
    end

    // ---------------------------------------------------------------------
    // Register bank, strobes and read-back datapath
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_reg[i] <= '0;
            end
            shadow_reg    <= '0;
            count_reg     <= '0;
            tx_rdy_reg    <= 1'b0;
            wr_strobe_reg <= '0;
            err_addr_reg  <= 1'b0;
        end else begin
            wr_strobe_reg <= '0;
            err_addr_reg  <= 1'b0;

            if (xfer) begin
                if (is_readback) begin
                    if (idx_ok) begin
                        shadow_reg <= regs_reg[in_data[IDX_W-1:0]];
                        count_reg  <= '0;
                        tx_rdy_reg <= 1'b1;
                    end else begin
                        err_addr_reg <= 1'b1;
                    end
                end else if (is_mapped) begin
                    regs_reg[addr_offset[IDX_W-1:0]]      <= in_data;
                    wr_strobe_reg[addr_offset[IDX_W-1:0]] <= 1'b1;
                end else begin
                    err_addr_reg <= 1'b1;
                end
            end

            // The shadow shifts right on each accepted packet. The current
            // packet therefore always sits in its low bits.
            if ((state_reg == ST_SEND) && tx_ack) begin
                shadow_reg <= shadow_reg >> TX_DATA_WIDTH;
                if (last_pkt) begin
                    tx_rdy_reg <= 1'b0;
                    count_reg  <= '0;
                end else begin
                    count_reg <= count_reg + CNT_W'(1);
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_flat
            assign regs_flat[gi*REG_DATA_WIDTH +: REG_DATA_WIDTH] = regs_reg[gi];
        end
    endgenerate

    assign tx_data   = shadow_reg[TX_DATA_WIDTH-1:0];
    assign tx_rdy    = tx_rdy_reg;
    assign wr_strobe = wr_strobe_reg;
    assign err_addr  = err_addr_reg;

endmodule
